// File: rtl/ahb_input_stage_dmam_if.sv
// Bus bundle for one master port of the DMA bus matrix: the master-facing
// AHB address/control signals (xxxS), the address phase passed on to the
// output stages (xxxM), and the request/grant/response wires that connect
// this input stage to the output-stage arbiters.
interface ahb_input_stage_dmam_if #(
    parameter int ADDR_WIDTH = 32
);
    // Master-facing side
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // Output-stage side
    logic                  HSELM;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic [1:0]            HTRANSM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [3:0]            HPROTM;
    logic                  HMASTLOCKM;
    logic                  req_port;
    logic                  active_trans;
    logic                  HREADYM;
    logic                  HRESPM;

    // The input stage itself
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_trans, HREADYM, HRESPM,
        output HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM,
               HBURSTM, HPROTM, HMASTLOCKM, req_port
    );

    // Everything around the input stage (master plus output stages)
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_trans, HREADYM, HRESPM,
        input  HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM,
               HBURSTM, HPROTM, HMASTLOCKM, req_port
    );
endinterface

// File: rtl/ahb_input_stage_dmam.sv
// Slave-side input stage of the DMA bus matrix (one per master port).
// A new transfer either goes straight through to the output stages on the
// live path, or, when the addressed output stage does not grant it, is
// parked in a holding register while wait states are returned to the
// master. The data-phase response of the selected slave is passed back.
module ahb_input_stage_dmam #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_input_stage_dmam_if.slave bus
);

    localparam logic [1:0] TRANS_IDLE = 2'b00;

    logic                  w_liveValid;
    logic                  w_newTran;
    logic                  w_accepted;

    logic                  w_hselM;
    logic [ADDR_WIDTH-1:0] w_haddrM;
    logic [1:0]            w_htransM;
    logic                  w_hwriteM;
    logic [2:0]            w_hsizeM;
    logic [2:0]            w_hburstM;
    logic [3:0]            w_hprotM;
    logic                  w_hmastlockM;

    logic                  r_pend;
    logic                  r_dataPhase;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [3:0]            r_hprot;
    logic                  r_hmastlock;

    // Bus HREADY qualifies the master's address phase; only NONSEQ/SEQ
    // carry a real transfer.
    assign w_liveValid = bus.HSELS & bus.HREADYS;
    assign w_newTran   = w_liveValid & bus.HTRANSS[1];

    // The output stage takes the presented address phase when it has this
    // port selected, is itself ready, and a real transfer is on offer.
    assign w_accepted  = bus.active_trans & bus.HREADYM & w_htransM[1];

    // Capture the whole address phase of every new transfer so it can be
    // replayed if the output stage cannot take it this cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_htrans    <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hburst    <= '0;
            r_hprot     <= '0;
            r_hmastlock <= 1'b0;
        end else if (w_newTran) begin
            r_haddr     <= bus.HADDRS;
            r_htrans    <= bus.HTRANSS;
            r_hwrite    <= bus.HWRITES;
            r_hsize     <= bus.HSIZES;
            r_hburst    <= bus.HBURSTS;
            r_hprot     <= bus.HPROTS;
            r_hmastlock <= bus.HMASTLOCKS;
        end
    end

    // A transfer stays pending from its issue until the cycle it is
    // accepted; the master cannot issue another while one is pending.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= (w_newTran | r_pend) & ~w_accepted;
        end
    end

    // Track whether the addressed slave is in a data phase for this port;
    // it only advances when the output stage's HREADY completes a cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dataPhase <= 1'b0;
        end else if (bus.HREADYM) begin
            r_dataPhase <= w_accepted;
        end
    end

    // Present either the held address phase or the live one; on the live
    // path an unqualified cycle is shown as IDLE so it cannot be mistaken
    // for a transfer.
    always_comb begin
        w_hselM      = bus.HSELS;
        w_haddrM     = bus.HADDRS;
        w_htransM    = w_liveValid ? bus.HTRANSS : TRANS_IDLE;
        w_hwriteM    = bus.HWRITES;
        w_hsizeM     = bus.HSIZES;
        w_hburstM    = bus.HBURSTS;
        w_hprotM     = bus.HPROTS;
        w_hmastlockM = bus.HMASTLOCKS;
        if (r_pend) begin
            w_hselM      = 1'b1;
            w_haddrM     = r_haddr;
            w_htransM    = r_htrans;
            w_hwriteM    = r_hwrite;
            w_hsizeM     = r_hsize;
            w_hburstM    = r_hburst;
            w_hprotM     = r_hprot;
            w_hmastlockM = r_hmastlock;
        end
    end

    assign bus.HSELM      = w_hselM;
    assign bus.HADDRM     = w_haddrM;
    assign bus.HTRANSM    = w_htransM;
    assign bus.HWRITEM    = w_hwriteM;
    assign bus.HSIZEM     = w_hsizeM;
    assign bus.HBURSTM    = w_hburstM;
    assign bus.HPROTM     = w_hprotM;
    assign bus.HMASTLOCKM = w_hmastlockM;

    // Request arbitration for a new transfer immediately, and keep asking
    // for as long as one is held.
    assign bus.req_port   = w_newTran | r_pend;

    // A held transfer always stalls the master; otherwise the slave's
    // ready is passed through during our data phase.
    assign bus.HREADYOUTS = r_pend ? 1'b0 : (r_dataPhase ? bus.HREADYM : 1'b1);

    // The response only belongs to this master during its own data phase,
    // and a pending transfer must not be aborted by it.
    assign bus.HRESPS     = (r_dataPhase & ~r_pend) ? bus.HRESPM : 1'b0;

endmodule
